// File: rtl/harris_frame_sched.sv
// -----------------------------------------------------------------------------
// harris_frame_sched
//
// Frame scheduler wrapped around an HLS Harris corner core. The host loads an
// image into the IMG buffer, kicks off a frame, and reads the corner response
// back out of the RES buffer once the core reports completion. The core sees
// both buffers as plain BRAM-style ports (ce/address/q and ce/we/address/d).
//
// Parameters
//   ADDR_W          word address width of both buffers (depth 2**ADDR_W)
//   DATA_W          buffer word width
//   TIMEOUT_CYCLES  watchdog limit in clocks (only with the watchdog build)
//
// Build option
//   HARRIS_SCHED_TIMEOUT_EN  when defined, a watchdog counter bounds the time
//                            spent in START/WAIT. On expiry the frame is
//                            abandoned and host_err is raised (sticky until
//                            the next accepted host_start or reset). When
//                            undefined, there is no counter and host_err is 0.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   host_start            frame-run request (accepted only in IDLE)
//   host_wr_en/addr/wdata host write into IMG (only in IDLE)
//   host_rd_en            host read from RES at host_addr
//   host_rdata/rvalid     read data one cycle after host_rd_en (0 while busy)
//   host_busy             frame in progress (START, WAIT, DONE)
//   host_done             one-cycle completion pulse
//   host_err              sticky watchdog flag
//   core_ap_*             HLS block-level handshake
//   core_img_*            core read port on IMG
//   core_harris_*         core write port on RES
// -----------------------------------------------------------------------------
module harris_frame_sched #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              host_start,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_rd_en,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_busy,
  output logic              host_done,
  output logic              host_err,

  output logic              core_ap_start,
  input  logic              core_ap_done,
  input  logic              core_ap_ready,

  input  logic              core_img_ce0,
  input  logic [ADDR_W-1:0] core_img_address0,
  output logic [DATA_W-1:0] core_img_q0,

  input  logic              core_harris_ce0,
  input  logic              core_harris_we0,
  input  logic [ADDR_W-1:0] core_harris_address0,
  input  logic [DATA_W-1:0] core_harris_d0
);

  localparam int DEPTH = 1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic   busy;
  logic   start_accept;

  assign busy         = (state_reg != IDLE);
  assign start_accept = (state_reg == IDLE) && host_start;

`ifdef HARRIS_SCHED_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             timeout;
  logic             err_set;
  logic             err_reg;

  // The counter holds the number of cycles already spent in START/WAIT, so
  // the cycle on which it shows TIMEOUT_CYCLES-1 is the last one allowed.
  assign timeout = ((state_reg == START) || (state_reg == WAIT)) &&
                   (cnt_reg >= CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_next = state_reg;
`ifdef HARRIS_SCHED_TIMEOUT_EN
    err_set    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (host_start) state_next = START;
      end
      START: begin
`ifdef HARRIS_SCHED_TIMEOUT_EN
        if (timeout) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else
`endif
        // ap_done together with ap_ready means the core finished within the
        // accepting cycle, so WAIT is skipped.
        if (core_ap_ready) state_next = core_ap_done ? DONE : WAIT;
      end
      WAIT: begin
`ifdef HARRIS_SCHED_TIMEOUT_EN
        if (timeout) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end else
`endif
        if (core_ap_done) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign core_ap_start = (state_reg == START);
  assign host_busy     = busy;
  assign host_done     = (state_reg == DONE);

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef HARRIS_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (start_accept) begin
      cnt_reg <= '0;
    end else if ((state_reg == START) || (state_reg == WAIT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end else if (start_accept) begin
      err_reg <= 1'b0;
    end
  end

  assign host_err = err_reg;
`else
  // Folds to a constant 0; referencing the parameter keeps it meaningful in
  // builds without the watchdog.
  assign host_err = (TIMEOUT_CYCLES < 0);
`endif

  // ---------------------------------------------------------------------------
  // IMG buffer: host write port (IDLE only), core read port.
  // Contents survive reset; only the read register is cleared.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] img_mem [DEPTH];
  logic [DATA_W-1:0] img_q_reg;

  always_ff @(posedge clk) begin
    if (host_wr_en && (state_reg == IDLE)) begin
      img_mem[host_addr] <= host_wdata;
    end
  end

  // Holds its last value when the core is not reading.
  always_ff @(posedge clk) begin
    if (!rst) begin
      img_q_reg <= '0;
    end else if (core_img_ce0) begin
      img_q_reg <= img_mem[core_img_address0];
    end
  end

  assign core_img_q0 = img_q_reg;

  // ---------------------------------------------------------------------------
  // RES buffer: core write port (any state), host read port.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] res_mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;

  always_ff @(posedge clk) begin
    if (core_harris_ce0 && core_harris_we0) begin
      res_mem[core_harris_address0] <= core_harris_d0;
    end
  end

  // Reads while a frame is running are still acknowledged so the host never
  // stalls, but return zero since RES may be half-written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= host_rd_en;
      if (host_rd_en) begin
        rdata_reg <= busy ? '0 : res_mem[host_addr];
      end
    end
  end

  assign host_rdata  = rdata_reg;
  assign host_rvalid = rvalid_reg;

endmodule

// File: tb/tb_harris_frame_sched.sv
module tb_harris_frame_sched;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int TO    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          host_start;
  logic          host_wr_en;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rd_en;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          host_busy;
  logic          host_done;
  logic          host_err;
  logic          core_ap_start;
  logic          core_ap_done;
  logic          core_ap_ready;
  logic          core_img_ce0;
  logic [AW-1:0] core_img_address0;
  logic [DW-1:0] core_img_q0;
  logic          core_harris_ce0;
  logic          core_harris_we0;
  logic [AW-1:0] core_harris_address0;
  logic [DW-1:0] core_harris_d0;

  harris_frame_sched #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .host_start(host_start), .host_wr_en(host_wr_en), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rd_en(host_rd_en), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_busy(host_busy), .host_done(host_done),
    .host_err(host_err), .core_ap_start(core_ap_start), .core_ap_done(core_ap_done),
    .core_ap_ready(core_ap_ready), .core_img_ce0(core_img_ce0),
    .core_img_address0(core_img_address0), .core_img_q0(core_img_q0),
    .core_harris_ce0(core_harris_ce0), .core_harris_we0(core_harris_we0),
    .core_harris_address0(core_harris_address0), .core_harris_d0(core_harris_d0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffer contents plus the expected output registers.
  logic [DW-1:0] img_m [DEPTH];
  logic [DW-1:0] res_m [DEPTH];
  logic [DW-1:0] q_m;
  logic [DW-1:0] rdata_m;
  logic          err_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    host_start           = 1'b0;
    host_wr_en           = 1'b0;
    host_addr            = '0;
    host_wdata           = '0;
    host_rd_en           = 1'b0;
    core_ap_done         = 1'b0;
    core_ap_ready        = 1'b0;
    core_img_ce0         = 1'b0;
    core_img_address0    = '0;
    core_harris_ce0      = 1'b0;
    core_harris_we0      = 1'b0;
    core_harris_address0 = '0;
    core_harris_d0       = '0;
  endtask

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // Apply one clock edge. busy_now is the model's view of whether a frame is
  // running during the cycle whose inputs are currently driven.
  task automatic tick(input logic busy_now);
    logic exp_rv;
    exp_rv = host_rd_en;
    if (host_rd_en) rdata_m = busy_now ? '0 : res_m[host_addr];
    if (core_img_ce0) q_m = img_m[core_img_address0];
    if (host_start && !busy_now) err_m = 1'b0;
    if (host_wr_en && !busy_now) img_m[host_addr] = host_wdata;
    if (core_harris_ce0 && core_harris_we0) res_m[core_harris_address0] = core_harris_d0;
    @(posedge clk);
    #1;
    chk("host_rvalid", 32'(host_rvalid), 32'(exp_rv));
    if (exp_rv) chk("host_rdata", host_rdata, rdata_m);
    chk("core_img_q0", core_img_q0, q_m);
    chk("host_err", 32'(host_err), 32'(err_m));
  endtask

  // Idle traffic: host writes IMG, host reads RES, core reads IMG.
  task automatic idle_ops(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      host_addr = raddr();
      if ($urandom_range(0, 1) == 1) begin
        host_wr_en = 1'b1;
        host_wdata = $urandom;
      end
      host_rd_en = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        core_img_ce0      = 1'b1;
        core_img_address0 = raddr();
        if (host_wr_en && core_img_address0 == host_addr) core_img_address0 ^= AW'(1);
      end
      tick(1'b0);
    end
    clear_inputs();
  endtask

  // One frame: core raises ap_ready r cycles after the frame starts, and
  // ap_done d cycles after that (d = 0 means both in the same cycle).
  task automatic run_frame(input int r, input int d, input bit dir);
    int n_as, n_busy, n_done, done_k;
    clear_inputs();
    host_start = 1'b1;
    if (dir) begin
      host_wr_en = 1'b1;
      host_addr  = AW'(5);
      host_wdata = 32'h0000_00AB;
    end else if ($urandom_range(0, 1) == 1) begin
      host_wr_en = 1'b1;
      host_addr  = raddr();
      host_wdata = $urandom;
    end
    tick(1'b0);
    n_as = 0; n_busy = 0; n_done = 0; done_k = -1;
    for (int k = 0; k < 64; k++) begin
      clear_inputs();
      if (!host_busy) break;
      if (dir && k == 1) chk("img5_read", core_img_q0, 32'h0000_00AB);
      if (core_ap_start) n_as++;
      n_busy++;
      if (host_done) begin
        n_done++;
        done_k = k;
      end
      core_ap_ready = (k == r);
      core_ap_done  = (k == r + d);
      // Host traffic during the frame must be ignored or read as zero.
      host_start = ($urandom_range(0, 1) == 1);
      host_addr  = raddr();
      host_wdata = $urandom;
      host_wr_en = ($urandom_range(0, 1) == 1);
      host_rd_en = ($urandom_range(0, 1) == 1);
      core_img_ce0      = ($urandom_range(0, 1) == 1);
      core_img_address0 = raddr();
      core_harris_ce0      = ($urandom_range(0, 1) == 1);
      core_harris_we0      = ($urandom_range(0, 1) == 1);
      core_harris_address0 = raddr();
      core_harris_d0       = $urandom;
      if (dir && k == 0) begin
        core_img_ce0      = 1'b1;
        core_img_address0 = AW'(5);
      end
      if (dir && k == r + 1) begin
        core_harris_ce0      = 1'b1;
        core_harris_we0      = 1'b1;
        core_harris_address0 = AW'(200);
        core_harris_d0       = 32'h1234_5678;
        host_wr_en = 1'b1;
        host_addr  = AW'(7);
        host_wdata = 32'h0000_00FF;
        host_rd_en = 1'b1;
        host_start = 1'b1;
      end
      tick(1'b1);
    end
    clear_inputs();
    chk("ap_start_cycles", n_as, r + 1);
    chk("busy_cycles", n_busy, r + d + 2);
    chk("done_pulses", n_done, 1);
    chk("done_cycle", done_k, r + d + 1);
    $display("[TB] frame r=%0d d=%0d ap_start=%0d busy=%0d done_at=%0d", r, d, n_as, n_busy, done_k);
  endtask

  initial begin
    int n_busy, n_done;
    clear_inputs();
    rst = 1'b0;
    q_m = '0; rdata_m = '0; err_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ap_start", 32'(core_ap_start), 0);
    chk("rst_busy", 32'(host_busy), 0);
    chk("rst_done", 32'(host_done), 0);
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_err", 32'(host_err), 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_img_q0", core_img_q0, 0);
    rst = 1'b1;

    // Fill both buffers so the model knows every word.
    for (int a = 0; a < DEPTH; a++) begin
      clear_inputs();
      host_wr_en = 1'b1;
      host_addr  = AW'(a);
      host_wdata = (a == 7) ? 32'h5A5A_5A5A : $urandom;
      tick(1'b0);
    end
    for (int a = 0; a < DEPTH; a++) begin
      clear_inputs();
      core_harris_ce0      = 1'b1;
      core_harris_we0      = 1'b1;
      core_harris_address0 = AW'(a);
      core_harris_d0       = $urandom;
      tick(1'b0);
    end
    idle_ops(40);

    // Directed frame: ready after 3 cycles, done 10 cycles later.
    run_frame(3, 10, 1'b1);
    clear_inputs();
    core_img_ce0      = 1'b1;
    core_img_address0 = AW'(7);
    host_rd_en        = 1'b1;
    host_addr         = AW'(200);
    tick(1'b0);
    chk("res200_read", host_rdata, 32'h1234_5678);
    chk("img7_kept", core_img_q0, 32'h5A5A_5A5A);
    clear_inputs();

    // Randomized frames, including ready+done in the same cycle.
    run_frame(0, 0, 1'b0);
    for (int f = 0; f < 12; f++) begin
      idle_ops(8);
      run_frame($urandom_range(0, 4), $urandom_range(0, 8), 1'b0);
    end
    idle_ops(8);

    // Reset in the middle of WAIT.
    clear_inputs();
    host_start = 1'b1;
    tick(1'b0);
    clear_inputs();
    core_ap_ready = 1'b1;
    tick(1'b1);
    clear_inputs();
    core_img_ce0      = 1'b1;
    core_img_address0 = AW'(7);
    tick(1'b1);
    clear_inputs();
    chk("mid_wait_busy", 32'(host_busy), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ap_start", 32'(core_ap_start), 0);
    chk("abort_busy", 32'(host_busy), 0);
    chk("abort_done", 32'(host_done), 0);
    chk("abort_rvalid", 32'(host_rvalid), 0);
    chk("abort_err", 32'(host_err), 0);
    chk("abort_rdata", host_rdata, 0);
    chk("abort_img_q0", core_img_q0, 0);
    q_m = '0; rdata_m = '0; err_m = 1'b0;
    rst = 1'b1;
    tick(1'b0);
    chk("post_abort_done", 32'(host_done), 0);
    chk("post_abort_busy", 32'(host_busy), 0);
    idle_ops(20);
    $display("[TB] reset during WAIT handled");

`ifdef HARRIS_SCHED_TIMEOUT_EN
    // Core never responds: the watchdog ends the frame after TO cycles.
    clear_inputs();
    host_start = 1'b1;
    tick(1'b0);
    n_busy = 0; n_done = 0;
    for (int k = 0; k < 64; k++) begin
      clear_inputs();
      if (!host_busy) break;
      n_busy++;
      if (host_done) n_done++;
      if (n_busy == TO) err_m = 1'b1;
      tick(1'b1);
    end
    chk("to_busy_cycles", n_busy, TO);
    chk("to_done", n_done, 0);
    chk("to_ap_start", 32'(core_ap_start), 0);
    clear_inputs();
    host_start = 1'b1;
    tick(1'b0);
    clear_inputs();
    core_ap_ready = 1'b1;
    core_ap_done  = 1'b1;
    tick(1'b1);
    clear_inputs();
    chk("to_recover_done", 32'(host_done), 1);
    tick(1'b1);
    chk("to_recover_idle", 32'(host_busy), 0);
    $display("[TB] watchdog frame handled");
`else
    n_busy = 0; n_done = 0;
    chk("no_watchdog_err", 32'(host_err), 32'(n_busy + n_done));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
